// File: rtl/mxv_result_sched.sv
// rtl/mxv_result_sched.sv - collects one 16-bit result per PE and streams it MSB-first as bytes
// Define MXV_SCHED_TERM_EN to append TERM_BYTE as an end-of-frame marker.
module mxv_result_sched #(
  parameter logic [7:0] TERM_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  N,
  input  logic        start,
  input  logic [7:0]  pe_empty,
  input  logic [15:0] pe_data,
  input  logic        tx_ready,
  output logic [2:0]  pe_sel,
  output logic        pop,
  output logic        tx_send,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_POP,
    S_LATCH,
    S_SEND_HI,
    S_SEND_LO,
    S_NEXT,
`ifdef MXV_SCHED_TERM_EN
    S_TERM,
`endif
    S_DONE
  } state_t;

  state_t      state;
  logic [15:0] hold;
  logic [3:0]  neff;

`ifdef MXV_SCHED_TERM_EN
  assign tx_send = (state == S_SEND_HI) || (state == S_SEND_LO) || (state == S_TERM);
`else
  assign tx_send = (state == S_SEND_HI) || (state == S_SEND_LO);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      pe_sel  <= 3'd0;
      pop     <= 1'b0;
      tx_data <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      hold    <= 16'h0000;
      neff    <= 4'd0;
    end else begin
      pop  <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            neff   <= (N > 8'd8) ? 4'd8 : N[3:0];
            pe_sel <= 3'd0;
            if (N == 8'd0) begin
`ifdef MXV_SCHED_TERM_EN
              tx_data <= TERM_BYTE;
              busy    <= 1'b1;
              state   <= S_TERM;
`else
              done    <= 1'b1;
              state   <= S_DONE;
`endif
            end else begin
              busy  <= 1'b1;
              state <= S_WAIT_DATA;
            end
          end
        end
        S_WAIT_DATA: begin
          if (!pe_empty[pe_sel]) begin
            pop   <= 1'b1;
            state <= S_POP;
          end
        end
        S_POP: state <= S_LATCH;
        S_LATCH: begin
          hold    <= pe_data;
          tx_data <= pe_data[15:8];
          state   <= S_SEND_HI;
        end
        S_SEND_HI: begin
          // Rotating keeps the low byte in front while preserving the full word.
          if (tx_ready) begin
            tx_data <= hold[7:0];
            hold    <= {hold[7:0], hold[15:8]};
            state   <= S_SEND_LO;
          end
        end
        S_SEND_LO: begin
          if (tx_ready) state <= S_NEXT;
        end
        S_NEXT: begin
          if ({1'b0, pe_sel} == neff - 4'd1) begin
`ifdef MXV_SCHED_TERM_EN
            tx_data <= TERM_BYTE;
            state   <= S_TERM;
`else
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= S_DONE;
`endif
          end else begin
            pe_sel <= pe_sel + 3'd1;
            state  <= S_WAIT_DATA;
          end
        end
`ifdef MXV_SCHED_TERM_EN
        S_TERM: begin
          if (tx_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
`endif
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mxv_result_sched.sv
// tb/tb_mxv_result_sched.sv - directed bench with a queue-based frame model for mxv_result_sched
module tb_mxv_result_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  N;
  logic        start;
  logic [7:0]  pe_empty;
  logic [15:0] pe_data;
  logic        tx_ready;
  logic [2:0]  pe_sel;
  logic        pop;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;

  mxv_result_sched dut (
    .clk(clk), .reset(reset), .N(N), .start(start), .pe_empty(pe_empty),
    .pe_data(pe_data), .tx_ready(tx_ready), .pe_sel(pe_sel), .pop(pop),
    .tx_send(tx_send), .tx_data(tx_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

`ifdef MXV_SCHED_TERM_EN
  localparam int TE = 1;
`else
  localparam int TE = 0;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] pe_words [8];
  logic [7:0]  exp_bytes [$];
  int          exp_pops [$];
  logic [7:0]  got_bytes [$];
  int pop_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event not expected by model", name);
  endtask

  // PE FIFO: the popped word appears on pe_data the cycle after pop.
  always @(posedge clk) if (pop) pe_data <= pe_words[pe_sel];

  always @(negedge clk) begin
    if (reset) begin
      if (pop) begin
        pop_cnt++;
        if (exp_pops.size() == 0) flag("pop_unexpected");
        else check("pop_sel", 32'(pe_sel), 32'(exp_pops.pop_front()));
        check("busy_at_pop", 32'(busy), 32'd1);
        if (tx_send) flag("pop_with_tx_send");
      end
      if (tx_send && tx_ready) begin
        got_bytes.push_back(tx_data);
        if (exp_bytes.size() == 0) flag("byte_unexpected");
        else check("tx_byte", 32'(tx_data), 32'(exp_bytes.pop_front()));
      end
      if (done) begin
        done_cnt++;
        check("done_busy_low", 32'(busy), 32'd0);
        check("done_bytes_left", 32'(exp_bytes.size()), 32'd0);
        check("done_pops_left", 32'(exp_pops.size()), 32'd0);
      end
    end
  end

  task automatic start_frame(input int n);
    int ne;
    ne = (n > 8) ? 8 : n;
    exp_bytes.delete(); exp_pops.delete(); got_bytes.delete();
    pop_cnt = 0;
    for (int i = 0; i < ne; i++) begin
      exp_bytes.push_back(pe_words[i][15:8]);
      exp_bytes.push_back(pe_words[i][7:0]);
      exp_pops.push_back(i);
    end
    if (TE == 1) exp_bytes.push_back(8'hFF);
    N = n[7:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    N = 8'hA5;
  endtask

  task automatic wait_done();
    int d0;
    int i;
    d0 = done_cnt;
    for (i = 0; i < 600 && done_cnt == d0; i++) @(posedge clk);
    if (done_cnt == d0) flag("done_timeout");
    #1;
  endtask

  task automatic wait_bytes(input int n);
    for (int i = 0; i < 200 && got_bytes.size() < n; i++) @(posedge clk);
    if (got_bytes.size() < n) flag("bytes_timeout");
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pe_sel"}, 32'(pe_sel), 32'd0);
    check({tag, "_pop"}, 32'(pop), 32'd0);
    check({tag, "_tx_send"}, 32'(tx_send), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'h00);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int d0;
    int seen;
    reset = 1'b1; start = 1'b0; N = 8'd0; pe_empty = 8'h00; tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) pe_words[i] = 16'h0000;
    #3 reset = 1'b0;
    #2 check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Basic three-row frame with hand-computed byte stream
    pe_words[0] = 16'h1234; pe_words[1] = 16'hABCD; pe_words[2] = 16'h0001;
    d0 = done_cnt;
    start_frame(3);
    wait_done();
    check("f3_nbytes", 32'(got_bytes.size()), 32'(6 + TE));
    if (got_bytes.size() >= 6) begin
      check("f3_b0", 32'(got_bytes[0]), 32'h12);
      check("f3_b1", 32'(got_bytes[1]), 32'h34);
      check("f3_b2", 32'(got_bytes[2]), 32'hAB);
      check("f3_b3", 32'(got_bytes[3]), 32'hCD);
      check("f3_b4", 32'(got_bytes[4]), 32'h00);
      check("f3_b5", 32'(got_bytes[5]), 32'h01);
    end
    if (TE == 1 && got_bytes.size() == 7) check("f3_term", 32'(got_bytes[6]), 32'hFF);
    check("f3_pops", 32'(pop_cnt), 32'd3);
    repeat (3) @(posedge clk);
    #1 check("f3_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Start while busy must be ignored; the next start after done begins at PE 0
    pe_words[0] = 16'h5566; pe_words[1] = 16'h7788; pe_words[2] = 16'h99AA;
    start_frame(3);
    repeat (6) @(posedge clk);
    #1 start = 1'b1; N = 8'd1;
    @(posedge clk); #1 start = 1'b0;
    wait_done();
    check("busy_start_pops", 32'(pop_cnt), 32'd3);
    start_frame(2);
    wait_done();
    check("restart_pops", 32'(pop_cnt), 32'd2);

    // PE1 empty: scheduler parks in WAIT_DATA on pe_sel=1
    pe_words[0] = 16'hBEEF; pe_words[1] = 16'hCAFE;
    pe_empty = 8'h02;
    start_frame(2);
    wait_bytes(2);
    @(posedge clk); #1;
    for (int k = 0; k < 20; k++) begin
      check("stall_pe_sel", 32'(pe_sel), 32'd1);
      check("stall_pop", 32'(pop), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    pe_empty = 8'h00;
    seen = 0;
    for (int k = 0; k < 2 && seen == 0; k++) begin
      @(posedge clk); #1;
      if (pop) seen = 1;
    end
    check("stall_resume_pop", 32'(seen), 32'd1);
    wait_done();

    // Transmitter back-pressure during the high byte
    pe_words[0] = 16'hC3A5;
    tx_ready = 1'b0;
    start_frame(1);
    seen = 0;
    for (int k = 0; k < 50 && seen == 0; k++) begin
      @(posedge clk); #1;
      if (tx_send) seen = 1;
    end
    check("bp_send_seen", 32'(seen), 32'd1);
    for (int k = 0; k < 10; k++) begin
      check("bp_tx_send", 32'(tx_send), 32'd1);
      check("bp_tx_data", 32'(tx_data), 32'hC3);
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    wait_done();
    check("bp_nbytes", 32'(got_bytes.size()), 32'(2 + TE));

    // Oversized N clamps to 8 PEs
    for (int i = 0; i < 8; i++) pe_words[i] = 16'(16'h1111 * (i + 1));
    start_frame(12);
    wait_done();
    check("n12_pops", 32'(pop_cnt), 32'd8);
    check("n12_nbytes", 32'(got_bytes.size()), 32'(16 + TE));

    // N=0: no pops, only the optional terminator
    d0 = done_cnt;
    start_frame(0);
    wait_done();
    check("n0_pops", 32'(pop_cnt), 32'd0);
    check("n0_nbytes", 32'(got_bytes.size()), 32'(TE));
    check("n0_done", 32'(done_cnt - d0), 32'd1);

    // Reset asserted in SEND_LO aborts the frame without a done pulse
    pe_words[0] = 16'h5AA5;
    start_frame(1);
    wait_bytes(1);
    #1 tx_ready = 1'b0;
    #2 reset = 1'b0;
    #1 check_idle_outputs("midreset");
    exp_bytes.delete(); exp_pops.delete();
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; tx_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    pe_words[0] = 16'h0F0F; pe_words[1] = 16'hF0F0;
    start_frame(2);
    wait_done();
    check("post_reset_pops", 32'(pop_cnt), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
